// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS sweep controller.
package dds_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE
    } state_t;

    // Waveform selects are active-low one-hot.
    localparam logic [2:0] SEL_SINE = 3'b110;
    localparam logic [2:0] SEL_SQR  = 3'b101;
    localparam logic [2:0] SEL_TRI  = 3'b011;

    localparam int unsigned FTW_100HZ = 138;

    // Next waveform in the sine -> square -> triangle rotation.
    function automatic logic [2:0] next_wave(input logic [2:0] cur);
        case (cur)
            SEL_SINE: return SEL_SQR;
            SEL_SQR:  return SEL_TRI;
            default:  return SEL_SINE;
        endcase
    endfunction

endpackage

// File: rtl/sweep_dwell_timer.sv
// Settle counter: loads a dwell count, decrements to zero and flags zero.
module sweep_dwell_timer #(
    parameter int unsigned W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency sweep sequencer: steps the tuning word, settles, requests one
// FFT capture per point and waits for the ack.
// Optional macro WAVE_CYCLE_EN: rotate sel_wave on each completed sweep
// instead of registering sel_in.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int unsigned FTW_W   = 32,
    parameter int unsigned DWELL_W = 24,
    parameter int unsigned NPTS_W  = 10,
    parameter int unsigned FTW_RST = FTW_100HZ
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [FTW_W-1:0]   cfg_ftw_start,
    input  logic [FTW_W-1:0]   cfg_ftw_step,
    input  logic [NPTS_W-1:0]  cfg_npts,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [2:0]         sel_in,
    output logic               cap_req,
    input  logic               cap_ack,
    output logic [FTW_W-1:0]   fre_k,
    output logic [2:0]         sel_wave,
    output logic               busy,
    output logic [NPTS_W-1:0]  pt_idx,
    output logic               pt_valid,
    output logic               done
);

    state_t              state, state_next;
    logic [FTW_W-1:0]    step_lat;
    logic [NPTS_W-1:0]   npts_lat;
    logic [DWELL_W-1:0]  dwell_lat;
    logic [DWELL_W-1:0]  dwell_val;
    logic                dwell_zero;
    logic                dwell_load, dwell_dec;
    logic                do_start, do_ack, req_set;
    logic                last_pt;

    assign last_pt   = (pt_idx == npts_lat - 1'b1);
    assign dwell_val = do_start ? cfg_dwell : dwell_lat;

    sweep_dwell_timer #(
        .W(DWELL_W)
    ) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (dwell_load),
        .load_val (dwell_val),
        .dec      (dwell_dec),
        .zero     (dwell_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-edge control strobes; abort overrides everything.
    always_comb begin
        state_next = state;
        do_start   = 1'b0;
        do_ack     = 1'b0;
        req_set    = 1'b0;
        dwell_load = 1'b0;
        dwell_dec  = 1'b0;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        do_start   = 1'b1;
                        dwell_load = 1'b1;
                        state_next = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (dwell_zero) begin
                        req_set    = 1'b1;
                        state_next = ST_CAPTURE;
                    end else begin
                        dwell_dec = 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (cap_ack) begin
                        do_ack = 1'b1;
                        if (last_pt) begin
                            state_next = ST_IDLE;
                        end else begin
                            dwell_load = 1'b1;
                            state_next = ST_SETTLE;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Registered outputs, sweep accumulator and latched sweep configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fre_k     <= FTW_W'(FTW_RST);
            pt_idx    <= '0;
            busy      <= 1'b0;
            cap_req   <= 1'b0;
            pt_valid  <= 1'b0;
            done      <= 1'b0;
            step_lat  <= '0;
            npts_lat  <= '0;
            dwell_lat <= '0;
        end else begin
            pt_valid <= 1'b0;
            done     <= 1'b0;
            if (abort) begin
                cap_req <= 1'b0;
                busy    <= 1'b0;
            end else begin
                if (do_start) begin
                    fre_k     <= cfg_ftw_start;
                    pt_idx    <= '0;
                    busy      <= 1'b1;
                    step_lat  <= cfg_ftw_step;
                    npts_lat  <= (cfg_npts == '0) ? NPTS_W'(1) : cfg_npts;
                    dwell_lat <= cfg_dwell;
                end
                if (req_set) begin
                    cap_req <= 1'b1;
                end
                if (do_ack) begin
                    cap_req  <= 1'b0;
                    pt_valid <= 1'b1;
                    if (last_pt) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        fre_k  <= fre_k + step_lat;
                        pt_idx <= pt_idx + 1'b1;
                    end
                end
            end
        end
    end

`ifdef WAVE_CYCLE_EN
    // Advance the waveform on the same edge that raises done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_wave <= SEL_SINE;
        end else if (do_ack && last_pt) begin
            sel_wave <= next_wave(sel_wave);
        end
    end
`else
    // Registered copy of the key-logic waveform select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_wave <= SEL_SINE;
        end else begin
            sel_wave <= sel_in;
        end
    end
`endif

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed testbench for dds_sweep_ctrl: table of sweeps plus hand-written
// abort, collision and reset sequences.
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] cfg_ftw_start = '0;
    logic [31:0] cfg_ftw_step = '0;
    logic [9:0]  cfg_npts = '0;
    logic [23:0] cfg_dwell = '0;
    logic [2:0]  sel_in = 3'b110;
    logic        cap_req;
    logic        cap_ack = 1'b0;
    logic [31:0] fre_k;
    logic [2:0]  sel_wave;
    logic        busy;
    logic [9:0]  pt_idx;
    logic        pt_valid;
    logic        done;

    dds_sweep_ctrl #(
        .FTW_W   (32),
        .DWELL_W (24),
        .NPTS_W  (10),
        .FTW_RST (138)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .cfg_ftw_start (cfg_ftw_start),
        .cfg_ftw_step  (cfg_ftw_step),
        .cfg_npts      (cfg_npts),
        .cfg_dwell     (cfg_dwell),
        .sel_in        (sel_in),
        .cap_req       (cap_req),
        .cap_ack       (cap_ack),
        .fre_k         (fre_k),
        .sel_wave      (sel_wave),
        .busy          (busy),
        .pt_idx        (pt_idx),
        .pt_valid      (pt_valid),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ftw_start;
        logic [31:0] step;
        logic [9:0]  npts;
        logic [23:0] dwell;
        int unsigned ack_dly;
        int unsigned exp_lat;
        int unsigned exp_pts;
        logic [31:0] exp_last;
    } vec_t;

    vec_t        vecs[4];
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          pv_cnt = 0;
    logic [2:0]  exp_wave = 3'b110;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (done)     done_cnt++;
            if (pt_valid) pv_cnt++;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output int unsigned lat);
        lat = 0;
        while (!cap_req && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    function automatic logic [2:0] rot(input logic [2:0] w);
        case (w)
            3'b110:  return 3'b101;
            3'b101:  return 3'b011;
            default: return 3'b110;
        endcase
    endfunction

    task automatic run_sweep(input vec_t v);
        int unsigned lat;
        logic [31:0] exp_ftw;
        int d0, p0;
        d0 = done_cnt;
        p0 = pv_cnt;
        cfg_ftw_start = v.ftw_start;
        cfg_ftw_step  = v.step;
        cfg_npts      = v.npts;
        cfg_dwell     = v.dwell;
        start = 1'b1;
        tick();
        start = 1'b0;
        // Scramble config: the running sweep must use its latched copy.
        cfg_ftw_step = '0;
        cfg_npts     = 10'd1;
        cfg_dwell    = 24'd9;
        check("start_busy", 32'(busy), 32'd1);
        check("start_ftw", fre_k, v.ftw_start);
        exp_ftw = v.ftw_start;
        for (int unsigned p = 0; p < v.exp_pts; p++) begin
            wait_req(lat);
            check("req_latency", lat, v.exp_lat);
            if (lat >= 200) return;
            check("point_ftw", fre_k, exp_ftw);
            check("point_idx", 32'(pt_idx), p);
            repeat (v.ack_dly) tick();
            check("req_held", 32'(cap_req), 32'd1);
            cap_ack = 1'b1;
            tick();
            cap_ack = 1'b0;
            check("ack_req_drop", 32'(cap_req), 32'd0);
            check("pt_valid", 32'(pt_valid), 32'd1);
            check("done_flag", 32'(done), 32'(p == v.exp_pts - 1));
            if (p != v.exp_pts - 1) exp_ftw += v.step;
        end
        check("last_ftw", fre_k, v.exp_last);
        check("end_busy", 32'(busy), 32'd0);
        tick();
        check("done_width", 32'(done), 32'd0);
        check("done_count", 32'(done_cnt - d0), 32'd1);
        check("pv_count", 32'(pv_cnt - p0), v.exp_pts);
`ifdef WAVE_CYCLE_EN
        exp_wave = rot(exp_wave);
`endif
        check("sel_wave_sweep", 32'(sel_wave), 32'(exp_wave));
    endtask

    initial begin
        int unsigned lat;
        int d0;

        vecs[0] = '{32'd138,        32'd3436,        10'd3, 24'd4, 2, 5, 3, 32'd7010};
        vecs[1] = '{32'd1000,       32'd5,           10'd0, 24'd0, 1, 1, 1, 32'd1000};
        vecs[2] = '{32'hFFFF_FF00,  32'h0000_0200,   10'd2, 24'd1, 3, 2, 2, 32'h0000_0100};
        vecs[3] = '{32'h0,          32'h4000_0000,   10'd4, 24'd2, 0, 3, 4, 32'hC000_0000};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Reset state
        check("rst_fre_k", fre_k, 32'd138);
        check("rst_sel_wave", 32'(sel_wave), 32'h6);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cap_req", 32'(cap_req), 32'd0);
        check("rst_pt_idx", 32'(pt_idx), 32'd0);
        check("rst_pt_valid", 32'(pt_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // Table of complete sweeps, back to back
        for (int i = 0; i < 4; i++) begin
            run_sweep(vecs[i]);
        end

        // Abort during the second capture, colliding with an ack
        cfg_ftw_start = 32'd138;
        cfg_ftw_step  = 32'd3436;
        cfg_npts      = 10'd3;
        cfg_dwell     = 24'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_req(lat);
        check("abort_lat1", lat, 32'd5);
        cap_ack = 1'b1;
        tick();
        cap_ack = 1'b0;
        wait_req(lat);
        check("abort_lat2", lat, 32'd5);
        check("abort_ftw_before", fre_k, 32'd3574);
        d0 = done_cnt;
        abort = 1'b1;
        cap_ack = 1'b1;
        tick();
        abort = 1'b0;
        cap_ack = 1'b0;
        check("abort_req", 32'(cap_req), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_pt_valid", 32'(pt_valid), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_ftw", fre_k, 32'd3574);
        check("abort_idx", 32'(pt_idx), 32'd1);
        repeat (8) tick();
        check("abort_req_later", 32'(cap_req), 32'd0);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_ftw_later", fre_k, 32'd3574);

        // abort and start together in IDLE: abort wins
        cfg_ftw_start = 32'd77;
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort_start_busy", 32'(busy), 32'd0);
        check("abort_start_ftw", fre_k, 32'd3574);
        tick();
        check("abort_start_req", 32'(cap_req), 32'd0);

        // start while busy and cap_ack during SETTLE are ignored
        cfg_ftw_start = 32'd500;
        cfg_ftw_step  = 32'd1;
        cfg_npts      = 10'd1;
        cfg_dwell     = 24'd6;
        start = 1'b1;
        tick();
        cfg_ftw_start = 32'd999;
        tick();
        start = 1'b0;
        check("busy_start_ftw", fre_k, 32'd500);
        check("busy_start_busy", 32'(busy), 32'd1);
        cap_ack = 1'b1;
        tick();
        cap_ack = 1'b0;
        check("early_ack_pv", 32'(pt_valid), 32'd0);
        check("early_ack_req", 32'(cap_req), 32'd0);
        wait_req(lat);
        check("ignored_lat", lat + 2, 32'd7);
        cap_ack = 1'b1;
        tick();
        cap_ack = 1'b0;
        check("ignored_done", 32'(done), 32'd1);
        check("ignored_ftw", fre_k, 32'd500);
`ifdef WAVE_CYCLE_EN
        exp_wave = rot(exp_wave);
`endif
        tick();
        check("ignored_sel_wave", 32'(sel_wave), 32'(exp_wave));

        // Reset asserted mid-sweep
        cfg_ftw_start = 32'd200;
        cfg_ftw_step  = 32'd10;
        cfg_npts      = 10'd5;
        cfg_dwell     = 24'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_req(lat);
        cap_ack = 1'b1;
        tick();
        cap_ack = 1'b0;
        check("mid_ftw", fre_k, 32'd210);
        tick();
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        check("mrst_ftw", fre_k, 32'd138);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_req", 32'(cap_req), 32'd0);
        check("mrst_idx", 32'(pt_idx), 32'd0);
        check("mrst_sel", 32'(sel_wave), 32'h6);
        exp_wave = 3'b110;
        tick();
        rst = 1'b0;
        repeat (6) tick();
        check("mrst_no_done", 32'(done_cnt - d0), 32'd0);
        check("mrst_idle", 32'(busy), 32'd0);

        // Waveform select path
`ifndef WAVE_CYCLE_EN
        sel_in = 3'b101;
        tick();
        check("sel_copy_sqr", 32'(sel_wave), 32'h5);
        sel_in = 3'b011;
        #1;
        check("sel_registered", 32'(sel_wave), 32'h5);
        tick();
        check("sel_copy_tri", 32'(sel_wave), 32'h3);
`else
        sel_in = 3'b011;
        tick();
        check("sel_in_ignored", 32'(sel_wave), 32'(exp_wave));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
